// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage pipelined register-bank / operand-mux / ALU datapath.
//   S1 holds the operands, which are read from the bank or the immediate.
//   S2 holds the registered ALU result and flags.
//   The ALU result is written back to the bank as the operation leaves S1.
//   The operation entering S1 on that same edge sees that result through a bypass.
// Ports:
//   clk, rst                   clock; synchronous reset, active low
//   in_valid/in_ready          upstream operation handshake
//   ra1, ra2, select_src,      operand selection (SrcB = constante when select_src)
//   constante, ULAControl      immediate operand and ALU opcode
//   wb_en, wb_addr             internal writeback of the result
//   we3, wa3, wd3              external register write port
//   out_valid/out_ready        downstream result handshake
//   ULAResult, Flag{Z,N,C,V}   registered result and flags
module datapath_pipe #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic             select_src,
  input  logic [WIDTH-1:0] constante,
  input  logic [2:0]       ULAControl,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ULAResult,
  output logic             FlagZ,
  output logic             FlagN,
  output logic             FlagC,
  output logic             FlagV
);
  localparam int STAGES = 2;
  localparam int SW     = $clog2(WIDTH);
  localparam int MSB    = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             we;
    logic [AW-1:0]    wa;
  } s1_t;

  logic [NREGS-1:0][WIDTH-1:0] rf;
  logic [STAGES:1]             vld_pipe;   // [1] = S1 valid, [2] = S2 valid
  s1_t                         s1;

  logic             out_fire, s1_adv, in_fire, wb_fire;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  assign out_valid = vld_pipe[2];
  assign out_fire  = vld_pipe[2] && out_ready;
  assign s1_adv    = vld_pipe[1] && (!vld_pipe[2] || out_fire);
  assign in_ready  = rst && (!vld_pipe[1] || s1_adv);
  assign in_fire   = in_valid && in_ready;
  assign wb_fire   = s1_adv && s1.we;

  // Operand read. A result being written back this edge is forwarded.
  // External writes are not forwarded, so a same-edge read sees the old value.
  always_comb begin
    op_a = rf[ra1];
    if (wb_fire && s1.wa == ra1) op_a = alu_res;
    op_b = rf[ra2];
    if (wb_fire && s1.wa == ra2) op_b = alu_res;
    if (select_src) op_b = constante;
  end

  always_comb begin
    add_s   = {1'b0, s1.a} + {1'b0, s1.b};
    sub_s   = {1'b0, s1.a} + {1'b0, ~s1.b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (s1.op)
      3'b000: begin
        alu_res = add_s[WIDTH-1:0];
        alu_c   = add_s[WIDTH];
        alu_v   = (s1.a[MSB] == s1.b[MSB]) && (alu_res[MSB] != s1.a[MSB]);
      end
      3'b001: begin
        alu_res = sub_s[WIDTH-1:0];
        alu_c   = sub_s[WIDTH];           // 1 = no borrow
        alu_v   = (s1.a[MSB] != s1.b[MSB]) && (alu_res[MSB] != s1.a[MSB]);
      end
      3'b010:  alu_res = s1.a & s1.b;
      3'b011:  alu_res = s1.a | s1.b;
      3'b100:  alu_res = s1.a ^ s1.b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1.a) < $signed(s1.b))};
      3'b110:  alu_res = s1.a << s1.b[SW-1:0];
      default: alu_res = s1.a >> s1.b[SW-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf        <= '0;
      vld_pipe  <= '0;
      s1        <= '0;
      ULAResult <= '0;
      FlagZ     <= 1'b0;
      FlagN     <= 1'b0;
      FlagC     <= 1'b0;
      FlagV     <= 1'b0;
    end else begin
      if (we3)     rf[wa3]   <= wd3;
      if (wb_fire) rf[s1.wa] <= alu_res;   // later assignment: writeback wins a collision
      if (in_fire) s1 <= '{a: op_a, b: op_b, op: ULAControl, we: wb_en, wa: wb_addr};
      vld_pipe[1] <= in_fire || (vld_pipe[1] && !s1_adv);
      vld_pipe[2] <= s1_adv  || (vld_pipe[2] && !out_fire);
      if (s1_adv) begin
        ULAResult <= alu_res;
        FlagZ     <= (alu_res == '0);
        FlagN     <= alu_res[MSB];
        FlagC     <= alu_c;
        FlagV     <= alu_v;
      end
    end
  end
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe.
// It drives two instances from one stimulus set: 8-bit/8-reg and 16-bit/16-reg.
// The instance not under test is held in reset.
module tb_datapath_pipe;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SLT = 3'b101, SHL = 3'b110, SHR = 3'b111;

  logic        clk = 1'b0, rst8 = 1'b0, rst16 = 1'b0, use16 = 1'b0;
  logic        in_valid = 1'b0, select_src = 1'b0, we3 = 1'b0, out_ready = 1'b1, wb_en = 1'b0;
  logic [3:0]  ra1 = '0, ra2 = '0, wb_addr = '0, wa3 = '0;
  logic [15:0] constante = '0, wd3 = '0;
  logic [2:0]  ula = '0;

  logic        rdy8, ov8, z8, n8, c8, v8, rdy16, ov16, z16, n16, c16, v16;
  logic [7:0]  res8;
  logic [15:0] res16;

  logic        rdy, ov;
  logic [15:0] res_o;
  logic [3:0]  fl_o;
  assign rdy   = use16 ? rdy16 : rdy8;
  assign ov    = use16 ? ov16  : ov8;
  assign res_o = use16 ? res16 : {8'h00, res8};
  assign fl_o  = use16 ? {z16, n16, c16, v16} : {z8, n8, c8, v8};

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  datapath_pipe #(.WIDTH(8), .NREGS(8)) d8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid), .in_ready(rdy8),
    .ra1(ra1[2:0]), .ra2(ra2[2:0]), .select_src(select_src), .constante(constante[7:0]),
    .ULAControl(ula), .wb_en(wb_en), .wb_addr(wb_addr[2:0]),
    .we3(we3), .wa3(wa3[2:0]), .wd3(wd3[7:0]),
    .out_valid(ov8), .out_ready(out_ready), .ULAResult(res8),
    .FlagZ(z8), .FlagN(n8), .FlagC(c8), .FlagV(v8));

  datapath_pipe #(.WIDTH(16), .NREGS(16)) d16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid), .in_ready(rdy16),
    .ra1(ra1), .ra2(ra2), .select_src(select_src), .constante(constante),
    .ULAControl(ula), .wb_en(wb_en), .wb_addr(wb_addr),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .out_valid(ov16), .out_ready(out_ready), .ULAResult(res16),
    .FlagZ(z16), .FlagN(n16), .FlagC(c16), .FlagV(v16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic set_rst(input logic v);
    if (use16) rst16 = v; else rst8 = v;
  endtask

  // All tasks begin and end just after a falling edge.
  task automatic do_reset(input string tag);
    in_valid = 1'b0; we3 = 1'b0; out_ready = 1'b1; set_rst(1'b0);
    step();
    chk({tag, ".rdy"}, rdy, 0);
    chk({tag, ".ov"},  ov, 0);
    chk({tag, ".res"}, res_o, 0);
    chk({tag, ".fl"},  fl_o, 0);
    set_rst(1'b1);
    step();
    chk({tag, ".rdy1"}, rdy, 1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    we3 = 1'b1; wa3 = a; wd3 = d;
    step();
    we3 = 1'b0;
  endtask

  // One isolated operation: accept, check latency, capture result, let it drain.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a1,
                        input logic [3:0] a2, input logic sel, input logic [15:0] k,
                        input logic wb, input logic [3:0] wba,
                        output logic [15:0] res, output logic [3:0] fl);
    ula = op; ra1 = a1; ra2 = a2; select_src = sel; constante = k;
    wb_en = wb; wb_addr = wba; in_valid = 1'b1;
    #1 chk({tag, ".rdy"}, rdy, 1);
    step();
    in_valid = 1'b0; we3 = 1'b0;
    chk({tag, ".lat"}, ov, 0);
    step();
    chk({tag, ".ov"}, ov, 1);
    res = res_o; fl = fl_o;
    step();
  endtask

  task automatic read_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] r;
    logic [3:0]  f;
    run_op(tag, ADD, a, 4'd0, 1'b1, 16'h0, 1'b0, 4'd0, r, f);
    chk(tag, r, exp);
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  ra;
    logic [15:0] k;
    logic [15:0] res;
    logic [3:0]  fl;    // {Z,N,C,V}
  } vec_t;
  vec_t vt [12];

  // Offer two ops with wb_en while downstream stalls, then reset on the edge
  // where S1 would otherwise advance and write back to target register wr_t.
  task automatic flight_reset(input string tag, input logic [3:0] wr_t);
    out_ready = 1'b0;
    ula = ADD; ra1 = 4'd0; select_src = 1'b1; wb_en = 1'b1;
    constante = 16'h44; wb_addr = 4'd3; in_valid = 1'b1;
    step();
    constante = 16'h66; wb_addr = wr_t;
    step();
    in_valid = 1'b0;
    #1 chk({tag, ".stall"}, rdy, 0);
    chk({tag, ".ov"}, ov, 1);
    set_rst(1'b0); out_ready = 1'b1;
    #1 chk({tag, ".rdyrst"}, rdy, 0);
    step();
    chk({tag, ".ovrst"}, ov, 0);
    chk({tag, ".resrst"}, res_o, 0);
    set_rst(1'b1);
    step();
    read_reg({tag, ".nowb"}, wr_t, 16'h0);
  endtask

  logic [15:0] r;
  logic [3:0]  f;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    // ---------------- 8-bit instance ----------------
    use16 = 1'b0;
    do_reset("rst8");
    wr(4'd1, 16'd5);
    run_op("add", ADD, 4'd1, 4'd0, 1'b1, 16'd3, 1'b1, 4'd2, r, f);
    chk("add.res", r, 8);
    chk("add.z", f[3], 0);
    read_reg("r2", 4'd2, 16'd8);

    // Dependent pair: r2 = r1 + r1, then r2 - r1 taken through the bypass.
    ula = ADD; ra1 = 4'd1; ra2 = 4'd1; select_src = 1'b0; wb_en = 1'b1; wb_addr = 4'd2;
    in_valid = 1'b1;
    step();
    ula = SUB; ra1 = 4'd2; ra2 = 4'd1; wb_en = 1'b0;
    #1 chk("b2b.rdy", rdy, 1);
    step();
    in_valid = 1'b0;
    chk("b2b.ov0", ov, 1);
    chk("b2b.res0", res_o, 16'h0A);
    step();
    chk("b2b.ov1", ov, 1);
    chk("b2b.res1", res_o, 16'h05);
    chk("b2b.fl1", fl_o, 4'b0010);
    step();
    chk("b2b.drain", ov, 0);
    read_reg("b2b.r2", 4'd2, 16'h0A);

    // Stall: three ops offered with out_ready low.
    out_ready = 1'b0;
    ula = ADD; ra1 = 4'd0; select_src = 1'b1; wb_en = 1'b0; constante = 16'd1; in_valid = 1'b1;
    #1 chk("st.rdy0", rdy, 1);
    step();
    constante = 16'd2;
    #1 chk("st.rdy1", rdy, 1);
    step();
    constante = 16'd3;
    #1 chk("st.full", rdy, 0);
    chk("st.ov", ov, 1);
    chk("st.h0", res_o, 1);
    step();
    chk("st.h1", res_o, 1);
    chk("st.rdy2", rdy, 0);
    step();
    chk("st.h2", res_o, 1);
    out_ready = 1'b1;
    #1 chk("st.rel", rdy, 1);
    step();
    in_valid = 1'b0;
    chk("st.o1", res_o, 2);
    chk("st.o1v", ov, 1);
    step();
    chk("st.o2", res_o, 3);
    chk("st.o2v", ov, 1);
    step();
    chk("st.empty", ov, 0);

    // ALU operations and flag boundaries. Registers: r0=0 r1=5 r5=7F r6=80 r7=FF.
    wr(4'd5, 16'h7F); wr(4'd6, 16'h80); wr(4'd7, 16'hFF);
    vt[0]  = {ADD,  4'd5, 16'h0001, 16'h0080, 4'b0101};
    vt[1]  = {SUB,  4'd0, 16'h0001, 16'h00FF, 4'b0100};
    vt[2]  = {SLT,  4'd6, 16'h0001, 16'h0001, 4'b0000};
    vt[3]  = {SUB,  4'd1, 16'h0005, 16'h0000, 4'b1010};
    vt[4]  = {ADD,  4'd7, 16'h0001, 16'h0000, 4'b1010};
    vt[5]  = {AND_, 4'd5, 16'h000F, 16'h000F, 4'b0000};
    vt[6]  = {OR_,  4'd6, 16'h0001, 16'h0081, 4'b0100};
    vt[7]  = {XOR_, 4'd5, 16'h007F, 16'h0000, 4'b1000};
    vt[8]  = {SHL,  4'd1, 16'h0003, 16'h0028, 4'b0000};
    vt[9]  = {SHR,  4'd6, 16'h0009, 16'h0040, 4'b0000};
    vt[10] = {SUB,  4'd6, 16'h0001, 16'h007F, 4'b0011};
    vt[11] = {SLT,  4'd1, 16'h0080, 16'h0000, 4'b1000};
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("alu%0d", i), vt[i].op, vt[i].ra, 4'd0, 1'b1, vt[i].k, 1'b0, 4'd0, r, f);
      chk($sformatf("alu%0d.res", i), r, vt[i].res);
      chk($sformatf("alu%0d.fl", i), f, vt[i].fl);
    end

    // External write during a read of the same register returns the old value.
    we3 = 1'b1; wa3 = 4'd5; wd3 = 16'h33;
    run_op("old", ADD, 4'd5, 4'd0, 1'b1, 16'h0, 1'b0, 4'd0, r, f);
    chk("old.res", r, 16'h7F);
    read_reg("old.r5", 4'd5, 16'h33);

    // Writeback and external write on the same edge, different then same address.
    for (int j = 0; j < 2; j++) begin
      ula = ADD; ra1 = 4'd0; select_src = 1'b1; wb_en = 1'b1; in_valid = 1'b1;
      constante = (j == 0) ? 16'h11 : 16'h55;
      wb_addr   = (j == 0) ? 4'd3 : 4'd4;
      step();
      in_valid = 1'b0; we3 = 1'b1; wa3 = 4'd4; wd3 = (j == 0) ? 16'h22 : 16'hAA;
      step();
      we3 = 1'b0;
      step();
    end
    read_reg("col.r3", 4'd3, 16'h11);
    read_reg("col.r4", 4'd4, 16'h55);

    flight_reset("fr8", 4'd0);
    run_op("resume8", ADD, 4'd0, 4'd0, 1'b1, 16'h07, 1'b1, 4'd2, r, f);
    chk("resume8.res", r, 16'h07);
    read_reg("resume8.r2", 4'd2, 16'h07);

    // ---------------- 16-bit instance ----------------
    rst8 = 1'b0;
    use16 = 1'b1;
    do_reset("rst16");
    wr(4'd9, 16'h7FFF);
    run_op("w16add", ADD, 4'd9, 4'd0, 1'b1, 16'h0001, 1'b0, 4'd0, r, f);
    chk("w16add.res", r, 16'h8000);
    chk("w16add.fl", f, 4'b0101);
    run_op("w16sub", SUB, 4'd0, 4'd0, 1'b1, 16'h0001, 1'b0, 4'd0, r, f);
    chk("w16sub.res", r, 16'hFFFF);
    chk("w16sub.fl", f, 4'b0100);
    run_op("w16shl", SHL, 4'd9, 4'd0, 1'b1, 16'd17, 1'b0, 4'd0, r, f);
    chk("w16shl.res", r, 16'hFFFE);
    flight_reset("fr16", 4'd15);
    run_op("resume16", ADD, 4'd0, 4'd0, 1'b1, 16'h1234, 1'b0, 4'd0, r, f);
    chk("resume16.res", r, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
